// File: rtl/credit_push_arbiter.sv
// credit_push_arbiter
//   Round-robin arbiter that pushes one payload per grant into a
//   credit-based FIFO. A grant is issued only while the link is
//   synchronized and spendable credits remain.
//
// Ports
//   push_clk                sole clock, rising edge
//   push_rst                synchronous active-high reset
//   req_valid/req_data      per-requester valid and payload (slice i = requester i)
//   req_ready               combinational one-hot grant (zero when nothing granted)
//   push_valid/push_data    registered push beat and its payload
//   push_grant_id           requester index of the current push beat
//   push_credit             one returned credit per cycle high
//   push_receiver_in_reset  receiver side of the FIFO is in reset
//   push_sender_in_reset    high while this side is not yet synchronized
//   credit_initial_push     credits loaded on leaving the sync state
//   credit_withhold_push    credits that are never spent
//   credit_count_push       current credit count
//   credit_available_push   spendable credits (count - withhold, floored at 0)
//   credit_error            sticky credit protocol error
//
// Build option
//   CREDIT_PUSH_ARBITER_ERR_EN  when defined, credit_error flags a credit
//   returned at the ceiling or beyond the initial allocation; otherwise it
//   is tied low and no checking logic is built.
module credit_push_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int CREDIT_WIDTH = 5,
  parameter int MAX_CREDITS  = 17
) (
  input  logic                          push_clk,
  input  logic                          push_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          push_valid,
  output logic [DATA_WIDTH-1:0]         push_data,
  output logic [2:0]                    push_grant_id,
  input  logic                          push_credit,
  input  logic                          push_receiver_in_reset,
  output logic                          push_sender_in_reset,
  input  logic [CREDIT_WIDTH-1:0]       credit_initial_push,
  input  logic [CREDIT_WIDTH-1:0]       credit_withhold_push,
  output logic [CREDIT_WIDTH-1:0]       credit_count_push,
  output logic [CREDIT_WIDTH-1:0]       credit_available_push,
  output logic                          credit_error
);

  localparam logic [0:0] S_SYNC = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [CREDIT_WIDTH-1:0] MAX_C = CREDIT_WIDTH'(MAX_CREDITS);

  logic [0:0]              state_q, state_d;
  logic                    low_cnt_q, low_cnt_d;
  logic [2:0]              rr_ptr_q, rr_ptr_d;
  logic [CREDIT_WIDTH-1:0] count_q, count_d;
  logic                    push_valid_q;
  logic [DATA_WIDTH-1:0]   push_data_q;
  logic [2:0]              grant_id_q;

  logic [CREDIT_WIDTH-1:0] avail_s;
  logic                    grant_en_s;
  logic                    found_s;
  logic                    grant_s;
  logic [2:0]              grant_idx_s;
  logic [NUM_REQ-1:0]      ready_s;
  logic [DATA_WIDTH-1:0]   grant_data_s;

  // Spendable credits: count minus withheld, floored at zero.
  always_comb begin
    if (count_q > credit_withhold_push) begin
      avail_s = count_q - credit_withhold_push;
    end else begin
      avail_s = {CREDIT_WIDTH{1'b0}};
    end
  end

  // Round-robin pick: first pass covers rr_ptr..NUM_REQ-1, second wraps from 0.
  always_comb begin
    grant_en_s  = !push_rst && (state_q == S_RUN) && !push_receiver_in_reset &&
                  (avail_s != {CREDIT_WIDTH{1'b0}});
    found_s     = 1'b0;
    grant_idx_s = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && req_valid[i] && (3'(i) >= rr_ptr_q)) begin
        found_s     = 1'b1;
        grant_idx_s = 3'(i);
      end else begin
        found_s     = found_s;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && req_valid[i]) begin
        found_s     = 1'b1;
        grant_idx_s = 3'(i);
      end else begin
        found_s     = found_s;
      end
    end
    grant_s = grant_en_s && found_s;
  end

  // One-hot ready and payload mux for the winning requester.
  always_comb begin
    ready_s      = {NUM_REQ{1'b0}};
    grant_data_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_s[i] = grant_s && (grant_idx_s == 3'(i));
      if (grant_idx_s == 3'(i)) begin
        grant_data_s = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
  end

  // Pointer moves just past the winner; holds when nothing is granted.
  always_comb begin
    if (grant_s) begin
      if (grant_idx_s == 3'(NUM_REQ - 1)) begin
        rr_ptr_d = 3'd0;
      end else begin
        rr_ptr_d = grant_idx_s + 3'd1;
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Sync/run state machine and credit counter next state.
  always_comb begin
    state_d   = state_q;
    low_cnt_d = low_cnt_q;
    count_d   = count_q;
    case (state_q)
      S_SYNC: begin
        // Credit returns are ignored here; the count just follows the load value.
        count_d = credit_initial_push;
        if (push_receiver_in_reset) begin
          low_cnt_d = 1'b0;
        end else if (low_cnt_q) begin
          state_d   = S_RUN;
          low_cnt_d = 1'b0;
        end else begin
          low_cnt_d = 1'b1;
        end
      end
      S_RUN: begin
        if (push_receiver_in_reset) begin
          state_d   = S_SYNC;
          low_cnt_d = 1'b0;
        end else begin
          state_d   = S_RUN;
        end
        // Grant and credit in the same cycle cancel out.
        if (grant_s && !push_credit) begin
          count_d = count_q - {{(CREDIT_WIDTH-1){1'b0}}, 1'b1};
        end else if (!grant_s && push_credit && (count_q != MAX_C)) begin
          count_d = count_q + {{(CREDIT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        state_d   = S_SYNC;
        low_cnt_d = 1'b0;
      end
    endcase
  end

  // State, pointer, credit count and push beat registers.
  always_ff @(posedge push_clk) begin
    if (push_rst) begin
      state_q      <= S_SYNC;
      low_cnt_q    <= 1'b0;
      rr_ptr_q     <= 3'd0;
      count_q      <= credit_initial_push;
      push_valid_q <= 1'b0;
      push_data_q  <= {DATA_WIDTH{1'b0}};
      grant_id_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      low_cnt_q    <= low_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      count_q      <= count_d;
      push_valid_q <= grant_s;
      if (grant_s) begin
        push_data_q <= grant_data_s;
        grant_id_q  <= grant_idx_s;
      end
    end
  end

`ifdef CREDIT_PUSH_ARBITER_ERR_EN
  logic err_set_s;
  logic err_q;

  // A credit is illegal at the ceiling or when it would exceed the allocation.
  always_comb begin
    err_set_s = (state_q == S_RUN) && push_credit &&
                ((count_q == MAX_C) ||
                 (({1'b0, count_q} + {{CREDIT_WIDTH{1'b0}}, 1'b1}) > {1'b0, credit_initial_push}));
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge push_clk) begin
    if (push_rst) begin
      err_q <= 1'b0;
    end else if (err_set_s) begin
      err_q <= 1'b1;
    end
  end

  assign credit_error = err_q;
`else
  assign credit_error = 1'b0;
`endif

  assign req_ready             = ready_s;
  assign push_valid            = push_valid_q;
  assign push_data             = push_data_q;
  assign push_grant_id         = grant_id_q;
  assign push_sender_in_reset  = (state_q == S_SYNC);
  assign credit_count_push     = count_q;
  assign credit_available_push = avail_s;

endmodule

// File: tb/tb_credit_push_arbiter.sv
module tb_credit_push_arbiter;

  logic        push_clk = 1'b0;
  logic        push_rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        push_valid;
  logic [7:0]  push_data;
  logic [2:0]  push_grant_id;
  logic        push_credit;
  logic        push_receiver_in_reset;
  logic        push_sender_in_reset;
  logic [4:0]  credit_initial_push;
  logic [4:0]  credit_withhold_push;
  logic [4:0]  credit_count_push;
  logic [4:0]  credit_available_push;
  logic        credit_error;

  int n_vec  = 0;
  int n_miss = 0;
  int beats  = 0;

  credit_push_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .CREDIT_WIDTH(5), .MAX_CREDITS(17)
  ) dut (
    .push_clk               (push_clk),
    .push_rst               (push_rst),
    .req_valid              (req_valid),
    .req_data               (req_data),
    .req_ready              (req_ready),
    .push_valid             (push_valid),
    .push_data              (push_data),
    .push_grant_id          (push_grant_id),
    .push_credit            (push_credit),
    .push_receiver_in_reset (push_receiver_in_reset),
    .push_sender_in_reset   (push_sender_in_reset),
    .credit_initial_push    (credit_initial_push),
    .credit_withhold_push   (credit_withhold_push),
    .credit_count_push      (credit_count_push),
    .credit_available_push  (credit_available_push),
    .credit_error           (credit_error)
  );

  always #5 push_clk = ~push_clk;

  task automatic tick();
    @(posedge push_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    push_rst               = 1'b1;
    push_receiver_in_reset = 1'b0;
    req_valid              = 4'h0;
    push_credit            = 1'b0;
    credit_initial_push    = 5'd17;
    credit_withhold_push   = 5'd0;
    req_data               = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Reset state
    tick();
    tick();
    chk("rst_sender", 32'(push_sender_in_reset), 32'd1);
    chk("rst_valid", 32'(push_valid), 32'd0);
    chk("rst_id", 32'(push_grant_id), 32'd0);
    chk("rst_data", 32'(push_data), 32'd0);
    chk("rst_count", 32'(credit_count_push), 32'd17);
    chk("rst_err", 32'(credit_error), 32'd0);
    req_valid = 4'hF;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);

    // Sync exit on the 2nd edge after release
    req_valid = 4'h0;
    push_rst  = 1'b0;
    tick();
    chk("sync_e1_sender", 32'(push_sender_in_reset), 32'd1);
    tick();
    chk("sync_e2_sender", 32'(push_sender_in_reset), 32'd0);
    chk("sync_count", 32'(credit_count_push), 32'd17);
    chk("sync_avail", 32'(credit_available_push), 32'd17);

    // Withhold 5: twelve beats, IDs 0..3 repeating
    credit_withhold_push = 5'd5;
    req_valid            = 4'hF;
    #1;
    chk("w_avail", 32'(credit_available_push), 32'd12);
    chk("w_ready0", 32'(req_ready), 32'h1);
    for (int k = 0; k < 15; k++) begin
      tick();
      if (push_valid === 1'b1) beats++;
      chk($sformatf("w_valid%0d", k), 32'(push_valid), (k < 12) ? 32'd1 : 32'd0);
      chk($sformatf("w_id%0d", k), 32'(push_grant_id), (k < 12) ? 32'(k % 4) : 32'd3);
      chk($sformatf("w_data%0d", k), 32'(push_data), (k < 12) ? 32'(8'hA0 + k % 4) : 32'hA3);
      chk($sformatf("w_count%0d", k), 32'(credit_count_push), (k < 12) ? 32'(16 - k) : 32'd5);
    end
    chk("w_beats", 32'(beats), 32'd12);
    chk("w_avail_end", 32'(credit_available_push), 32'd0);
    chk("w_ready_end", 32'(req_ready), 32'd0);

    // Two credit pulses: two beats, IDs 0 then 1
    push_credit = 1'b1;
    tick();
    chk("c1_count", 32'(credit_count_push), 32'd6);
    chk("c1_valid", 32'(push_valid), 32'd0);
    push_credit = 1'b0;
    #1;
    chk("c1_ready", 32'(req_ready), 32'h1);
    tick();
    chk("c1_beat", 32'(push_valid), 32'd1);
    chk("c1_id", 32'(push_grant_id), 32'd0);
    chk("c1_count2", 32'(credit_count_push), 32'd5);
    push_credit = 1'b1;
    tick();
    chk("c2_count", 32'(credit_count_push), 32'd6);
    chk("c2_valid", 32'(push_valid), 32'd0);
    push_credit = 1'b0;
    tick();
    chk("c2_beat", 32'(push_valid), 32'd1);
    chk("c2_id", 32'(push_grant_id), 32'd1);
    chk("c2_data", 32'(push_data), 32'hA1);
    tick();
    chk("c2_after_valid", 32'(push_valid), 32'd0);
    chk("c2_avail", 32'(credit_available_push), 32'd0);

    // Raise count to 10, then grant and credit together
    req_valid   = 4'h0;
    push_credit = 1'b1;
    repeat (5) tick();
    chk("to10_count", 32'(credit_count_push), 32'd10);
    req_valid = 4'b0100;
    #1;
    chk("both_ready", 32'(req_ready), 32'b0100);
    tick();
    chk("both_count", 32'(credit_count_push), 32'd10);
    chk("both_valid", 32'(push_valid), 32'd1);
    chk("both_id", 32'(push_grant_id), 32'd2);
    chk("both_data", 32'(push_data), 32'hA2);

    // Wrap-around search from pointer 3
    push_credit = 1'b0;
    req_valid   = 4'b0011;
    #1;
    chk("rr_ready_a", 32'(req_ready), 32'b0001);
    tick();
    chk("rr_id_a", 32'(push_grant_id), 32'd0);
    chk("rr_count_a", 32'(credit_count_push), 32'd9);
    chk("rr_ready_b", 32'(req_ready), 32'b0010);
    tick();
    chk("rr_id_b", 32'(push_grant_id), 32'd1);
    chk("rr_count_b", 32'(credit_count_push), 32'd8);
    req_valid = 4'h0;
    tick();
    chk("hold_valid", 32'(push_valid), 32'd0);
    chk("hold_id", 32'(push_grant_id), 32'd1);
    chk("hold_data", 32'(push_data), 32'hA1);

    // Saturation at the ceiling
    push_credit = 1'b1;
    repeat (9) tick();
    chk("sat_reach", 32'(credit_count_push), 32'd17);
`ifdef CREDIT_PUSH_ARBITER_ERR_EN
    chk("sat_err_before", 32'(credit_error), 32'd0);
`endif
    tick();
    chk("sat_hold", 32'(credit_count_push), 32'd17);
    push_credit = 1'b0;
    tick();
`ifdef CREDIT_PUSH_ARBITER_ERR_EN
    chk("sat_err", 32'(credit_error), 32'd1);
`else
    chk("sat_err", 32'(credit_error), 32'd0);
`endif

    // Receiver reset pulse mid-traffic
    req_valid = 4'hF;
    #1;
    chk("rr_ready_c", 32'(req_ready), 32'b0100);
    tick();
    chk("rx_beat", 32'(push_valid), 32'd1);
    chk("rx_beat_id", 32'(push_grant_id), 32'd2);
    chk("rx_count", 32'(credit_count_push), 32'd16);
    push_receiver_in_reset = 1'b1;
    #1;
    chk("rx_ready", 32'(req_ready), 32'd0);
    tick();
    chk("rx_sender", 32'(push_sender_in_reset), 32'd1);
    chk("rx_valid", 32'(push_valid), 32'd0);
    push_receiver_in_reset = 1'b0;
    tick();
    chk("rx_sync1", 32'(push_sender_in_reset), 32'd1);
    chk("rx_reload", 32'(credit_count_push), 32'd17);
    tick();
    chk("rx_run", 32'(push_sender_in_reset), 32'd0);
    chk("rx_count_run", 32'(credit_count_push), 32'd17);
    chk("rx_ready_run", 32'(req_ready), 32'b1000);
    tick();
    chk("rx_resume_id", 32'(push_grant_id), 32'd3);
    chk("rx_resume_valid", 32'(push_valid), 32'd1);

    // A high sample in sync clears the consecutive-low count
    req_valid              = 4'h0;
    push_receiver_in_reset = 1'b1;
    tick();
    push_receiver_in_reset = 1'b0;
    tick();
    push_receiver_in_reset = 1'b1;
    tick();
    push_receiver_in_reset = 1'b0;
    tick();
    chk("clr_still_sync", 32'(push_sender_in_reset), 32'd1);
    tick();
    chk("clr_run", 32'(push_sender_in_reset), 32'd0);

    // Reset wins over a grant and a credit in the same cycle
    credit_initial_push = 5'd9;
    req_valid           = 4'hF;
    push_credit         = 1'b1;
    push_rst            = 1'b1;
    #1;
    chk("prio_ready", 32'(req_ready), 32'd0);
    tick();
    chk("prio_valid", 32'(push_valid), 32'd0);
    chk("prio_id", 32'(push_grant_id), 32'd0);
    chk("prio_data", 32'(push_data), 32'd0);
    chk("prio_count", 32'(credit_count_push), 32'd9);
    chk("prio_sender", 32'(push_sender_in_reset), 32'd1);
    chk("prio_err", 32'(credit_error), 32'd0);
    push_rst    = 1'b0;
    push_credit = 1'b0;
    req_valid   = 4'h0;
    tick();
    tick();
    chk("post_sender", 32'(push_sender_in_reset), 32'd0);
    chk("post_count", 32'(credit_count_push), 32'd9);
    chk("post_avail", 32'(credit_available_push), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/credit_push_arbiter.md
CREDIT_PUSH_ARBITER -- requirements
Module: credit_push_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  NUM_REQ, 4, requester count (2..8)
  DATA_WIDTH, 8, push payload width
  CREDIT_WIDTH, 5, credit counter width
  MAX_CREDITS, 17, counter saturation ceiling (<= 2^CREDIT_WIDTH-1)
REQ-002 Ports SHALL be (name, direction, width, meaning):
  push_clk  in  1  sole clock, rising edge
  push_rst  in  1  synchronous, active-high reset
  req_valid  in  NUM_REQ  per-requester valid
  req_data  in  NUM_REQ*DATA_WIDTH  per-requester payload; slice i = requester i
  req_ready  out  NUM_REQ  one-hot grant/accept
  push_valid  out  1  registered push to credit FIFO
  push_data  out  DATA_WIDTH  registered payload
  push_grant_id  out  3  requester index of current push_valid beat
  push_credit  in  1  one credit returned per cycle high
  push_receiver_in_reset  in  1  FIFO receiver side in reset
  push_sender_in_reset  out  1  arbiter not yet synchronized
  credit_initial_push  in  CREDIT_WIDTH  credits loaded at sync exit
  credit_withhold_push  in  CREDIT_WIDTH  credits never spent
  credit_count_push  out  CREDIT_WIDTH  current credit count
  credit_available_push  out  CREDIT_WIDTH  spendable credits
  credit_error  out  1  sticky protocol error (see REQ-019)

Function
REQ-003 State machine SHALL have two states: S_SYNC and S_RUN; push_sender_in_reset SHALL equal 1 exactly when state is S_SYNC.
REQ-004 S_SYNC SHALL go to S_RUN on the edge at which push_receiver_in_reset is sampled low for the second consecutive cycle; any high sample SHALL clear the consecutive-low count.
REQ-005 On the S_SYNC->S_RUN edge credit_count_push SHALL load credit_initial_push; throughout S_SYNC it SHALL track credit_initial_push.
REQ-006 S_RUN SHALL go to S_SYNC on the edge after push_receiver_in_reset is sampled high; a push_valid beat already registered SHALL still be presented that cycle, no new grant SHALL issue.
REQ-007 credit_available_push SHALL be credit_count_push - credit_withhold_push, saturating at 0 (combinational).
REQ-008 A grant SHALL be possible only when state is S_RUN, push_receiver_in_reset is 0 and credit_available_push > 0.
REQ-009 Arbitration SHALL be round-robin: search starts at pointer rr_ptr, first i with req_valid[i]=1 wins; req_ready SHALL be combinational, one-hot or zero.
REQ-010 On a grant to i, rr_ptr SHALL become (i+1) mod NUM_REQ; without a grant rr_ptr SHALL hold.
REQ-011 Latency: grant in cycle N SHALL produce push_valid=1, push_data=req_data slice i, push_grant_id=i in cycle N+1; push_valid SHALL be 1 for exactly one cycle per grant.
REQ-012 At most one grant per cycle; back-to-back grants every cycle SHALL be supported while credits last.
REQ-013 Credit update per cycle: grant only -> count-1; push_credit only -> count+1; both -> unchanged; neither -> unchanged.
REQ-014 push_credit in S_SYNC SHALL be ignored.
REQ-015 Increment at count==MAX_CREDITS SHALL saturate (count holds).
REQ-016 push_data and push_grant_id SHALL hold previous value when push_valid=0.

Reset
REQ-017 With push_rst=1 at an edge: state S_SYNC, consecutive-low count 0, rr_ptr 0, push_valid 0, push_data 0, push_grant_id 0, credit_count_push=credit_initial_push, credit_error 0; req_ready SHALL be 0 during reset.
REQ-018 Reset SHALL take priority over every other update, including a grant or credit arriving the same cycle.

Configuration
REQ-019 With macro CREDIT_PUSH_ARBITER_ERR_EN defined, credit_error SHALL set (sticky until push_rst) on push_credit at count==MAX_CREDITS or on push_credit while credit_count_push+1 exceeds credit_initial_push; without it credit_error SHALL be constant 0 and the check logic absent.

Verification
REQ-020 Reset released, push_receiver_in_reset=0 -> push_sender_in_reset falls on 2nd edge after release; credit_count_push=17, credit_available_push=17.
REQ-021 initial 17, withhold 5, all four req_valid=1, no push_credit -> exactly 12 push_valid beats, grant IDs 0,1,2,3 repeating, then none; credit_available_push=0.
REQ-022 Continue REQ-021, two push_credit pulses -> two beats, IDs 0 then 1; credit_available_push returns to 0.
REQ-023 push_credit and grant same cycle at count 10 -> count stays 10; push_valid next cycle.
REQ-024 push_receiver_in_reset pulsed high 1 cycle mid-traffic -> grants stop, push_sender_in_reset=1, resync after 2 low samples, count reloads credit_initial_push.
REQ-025 ERR_EN defined, count 17, push_credit=1 -> count stays 17, credit_error=1 until push_rst.
